// File: rtl/gather_apply_unit_pkg.sv
// Shared definitions for the gather-phase read-modify-write unit.
//   OP_MIN / OP_ADD : combine-function selectors for the OP parameter
//   state_t         : run-control FSM states
//   comb_t          : result of combine() (new property + write condition)
//   combine()       : merges the current property with one update
package gather_pkg;

   localparam int OP_MIN = 0;
   localparam int OP_ADD = 1;

   // combine() works at a fixed wide width; callers zero-extend their
   // DATA-bit operands and keep the low DATA bits of the result.
   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [MAX_W-1:0] new_val;
      logic             wr;
   } comb_t;

   // min: only a strictly smaller value is worth a write.
   // add: adding zero leaves the property untouched, so skip the write.
   function automatic comb_t combine(input logic [MAX_W-1:0] old,
                                     input logic [MAX_W-1:0] value,
                                     input int               op);
      comb_t r;
      if (op == OP_ADD) begin
         r.new_val = old + value;
         r.wr      = (value != '0);
      end else begin
         r.wr      = (value < old);
         r.new_val = r.wr ? value : old;
      end
      return r;
   endfunction

endpackage

// File: rtl/gather_apply_unit_if.sv
// Update stream from the gather FIFO into gather_apply_unit.
//   upd_valid/upd_ready : handshake, transfer when both high
//   upd_addr            : destination vertex
//   upd_value           : update operand
//   upd_last            : final update of the run
// master = FIFO side, slave = gather_apply_unit side.
interface gather_apply_unit_if #(
   parameter int ADDR = 16,
   parameter int DATA = 32
);
   logic            upd_valid;
   logic            upd_ready;
   logic [ADDR-1:0] upd_addr;
   logic [DATA-1:0] upd_value;
   logic            upd_last;

   modport master (
      output upd_valid, upd_addr, upd_value, upd_last,
      input  upd_ready
   );

   modport slave (
      input  upd_valid, upd_addr, upd_value, upd_last,
      output upd_ready
   );
endinterface

// File: rtl/gather_apply_unit.sv
// Read-modify-write client for one vertex-property dual-port RAM.
// Each accepted update reads the property through port A, combines it
// with the update (min or add) and writes the result back through port B
// one edge later. Back-to-back hits on the same vertex are forwarded so
// the unit takes one update per cycle with no stalls.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse starting a run (ignored outside IDLE)
//   upd          : update stream (slave side)
//   mem_a_addr   : port A read address (port A write enable is tied low
//                  where the RAM is instantiated)
//   mem_a_dout   : port A registered, read-first read data
//   mem_b_wr/addr/din : port B write
//   done         : one-cycle pulse once the run has fully committed
//   changed      : sticky, some property changed during this run
//   num_writes   : RAM writes this run, wrapping
module gather_apply_unit
   import gather_pkg::*;
#(
   parameter int DATA = 32,   // must not exceed gather_pkg::MAX_W
   parameter int ADDR = 16,
   parameter int OP   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   gather_apply_unit_if.slave   upd,
   output logic [ADDR-1:0]      mem_a_addr,
   input  logic [DATA-1:0]      mem_a_dout,
   output logic                 mem_b_wr,
   output logic [ADDR-1:0]      mem_b_addr,
   output logic [DATA-1:0]      mem_b_din,
   output logic                 done,
   output logic                 changed,
   output logic [31:0]          num_writes
);

   state_t state, state_nx;

   logic            accept_p0;

   logic            s2_vld_p1;
   logic [ADDR-1:0] s2_addr_p1;
   logic [DATA-1:0] s2_val_p1;

   logic            fwd_vld_p2;
   logic [ADDR-1:0] fwd_addr_p2;
   logic [DATA-1:0] fwd_data_p2;

   logic [DATA-1:0]  old_p1;
   comb_t            res_p1;
   logic [MAX_W-1:0] new_wide_p1;
   logic [DATA-1:0]  new_p1;
   logic             wr_p1;
   logic             unused_new_bits;

   // ---- S0: acceptance; the RAM samples the read address on this edge
   assign upd.upd_ready = (state == RUN);
   assign accept_p0     = upd.upd_valid & upd.upd_ready;
   assign mem_a_addr    = upd.upd_addr;

   // ---- S2: combine with the property read on the previous edge
   // The RAM is read-first: if the write for the previous update hit the
   // same vertex on the very edge this read was sampled, mem_a_dout is
   // stale and F carries the committed value instead.
   assign old_p1 = (fwd_vld_p2 && (fwd_addr_p2 == s2_addr_p1)) ? fwd_data_p2
                                                               : mem_a_dout;

   assign res_p1          = combine(MAX_W'(old_p1), MAX_W'(s2_val_p1), OP);
   assign new_wide_p1     = res_p1.new_val;
   assign new_p1          = new_wide_p1[DATA-1:0];
   assign unused_new_bits = ^new_wide_p1;
   assign wr_p1           = s2_vld_p1 & res_p1.wr;

   assign mem_b_wr   = wr_p1;
   assign mem_b_addr = s2_addr_p1;
   // Hold the write bus at zero while S2 is empty rather than echoing
   // whatever the read port happens to return.
   assign mem_b_din  = s2_vld_p1 ? new_p1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_p1   <= 1'b0;
         s2_addr_p1  <= '0;
         s2_val_p1   <= '0;
         fwd_vld_p2  <= 1'b0;
         fwd_addr_p2 <= '0;
         fwd_data_p2 <= '0;
      end else begin
         s2_vld_p1 <= accept_p0;
         if (accept_p0) begin
            s2_addr_p1 <= upd.upd_addr;
            s2_val_p1  <= upd.upd_value;
         end
         // ---- F: remembers only the write committed on the last edge
         fwd_vld_p2 <= wr_p1;
         if (wr_p1) begin
            fwd_addr_p2 <= s2_addr_p1;
            fwd_data_p2 <= new_p1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         changed    <= 1'b0;
         num_writes <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            changed    <= 1'b0;
            num_writes <= '0;
         end else if (wr_p1) begin
            changed    <= 1'b1;
            num_writes <= num_writes + 32'd1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (accept_p0 && upd.upd_last) state_nx = DRAIN;
         DRAIN:   if (!s2_vld_p1) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign done = (state == DONE);

endmodule

// File: tb/tb_gather_apply_unit.sv
module tb_gather_apply_unit;

   localparam int DATA = 32;
   localparam int ADDR = 16;

   typedef struct packed {
      logic            wr;
      logic [ADDR-1:0] a;
      logic [DATA-1:0] d;
   } exp_t;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;

   always #5 clk = ~clk;

   gather_apply_unit_if #(.ADDR(ADDR), .DATA(DATA)) u0 ();
   gather_apply_unit_if #(.ADDR(ADDR), .DATA(DATA)) u1 ();

   logic [ADDR-1:0] a_addr0, b_addr0, a_addr1, b_addr1;
   logic [DATA-1:0] dout0, din0, dout1, din1;
   logic            wr0, wr1, done0, done1, changed0, changed1;
   logic [31:0]     nw0, nw1;

   gather_apply_unit #(.DATA(DATA), .ADDR(ADDR), .OP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .upd(u0),
      .mem_a_addr(a_addr0), .mem_a_dout(dout0),
      .mem_b_wr(wr0), .mem_b_addr(b_addr0), .mem_b_din(din0),
      .done(done0), .changed(changed0), .num_writes(nw0)
   );

   gather_apply_unit #(.DATA(DATA), .ADDR(ADDR), .OP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .upd(u1),
      .mem_a_addr(a_addr1), .mem_a_dout(dout1),
      .mem_b_wr(wr1), .mem_b_addr(b_addr1), .mem_b_din(din1),
      .done(done1), .changed(changed1), .num_writes(nw1)
   );

   // Dual-port RAMs: port A registered read-first, port B write, plus a
   // bench-only preload port.
   logic [DATA-1:0] ram0 [0:(1<<ADDR)-1];
   logic [DATA-1:0] ram1 [0:(1<<ADDR)-1];
   logic            pl_en0 = 1'b0, pl_en1 = 1'b0;
   logic [ADDR-1:0] pl_addr = '0;
   logic [DATA-1:0] pl_data = '0;

   always @(posedge clk) begin
      dout0 <= ram0[a_addr0];
      if (wr0) ram0[b_addr0] <= din0;
      if (pl_en0) ram0[pl_addr] <= pl_data;
   end

   always @(posedge clk) begin
      dout1 <= ram1[a_addr1];
      if (wr1) ram1[b_addr1] <= din1;
      if (pl_en1) ram1[pl_addr] <= pl_data;
   end

   logic [DATA-1:0] ref0 [0:15];
   logic [DATA-1:0] ref1 [0:15];
   exp_t            q0[$];
   exp_t            q1[$];
   int              total = 0;
   int              bad   = 0;
   int              exp_nw0 = 0;
   int              exp_nw1 = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: compute expected write for an accepted update.
   task automatic model(input int sel, input logic [ADDR-1:0] a, input logic [DATA-1:0] v);
      exp_t            e;
      logic [DATA-1:0] old;
      old  = (sel == 0) ? ref0[a[3:0]] : ref1[a[3:0]];
      e.a  = a;
      e.wr = 1'b0;
      e.d  = old;
      if (sel == 0) begin
         if (v < old) begin e.wr = 1'b1; e.d = v; end
      end else begin
         if (v != '0) begin e.wr = 1'b1; e.d = old + v; end
      end
      if (sel == 0) begin
         if (e.wr) begin ref0[a[3:0]] = e.d; exp_nw0++; end
         q0.push_back(e);
      end else begin
         if (e.wr) begin ref1[a[3:0]] = e.d; exp_nw1++; end
         q1.push_back(e);
      end
   endtask

   task automatic cycle();
      exp_t e;
      if (u0.upd_valid && u0.upd_ready) model(0, u0.upd_addr, u0.upd_value);
      if (u1.upd_valid && u1.upd_ready) model(1, u1.upd_addr, u1.upd_value);
      @(posedge clk);
      @(negedge clk);
      if (q0.size() > 0) begin
         e = q0.pop_front();
         chk("b_wr0", wr0, e.wr);
         if (e.wr) begin
            chk("b_addr0", b_addr0, e.a);
            chk("b_din0", din0, e.d);
         end
      end else chk("b_idle0", wr0, 1'b0);
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk("b_wr1", wr1, e.wr);
         if (e.wr) begin
            chk("b_addr1", b_addr1, e.a);
            chk("b_din1", din1, e.d);
         end
      end else chk("b_idle1", wr1, 1'b0);
   endtask

   task automatic send(input int sel, input logic [ADDR-1:0] a, input logic [DATA-1:0] v,
                       input logic last);
      u0.upd_valid = (sel == 0);
      u1.upd_valid = (sel == 1);
      if (sel == 0) begin
         u0.upd_addr = a; u0.upd_value = v; u0.upd_last = last;
      end else begin
         u1.upd_addr = a; u1.upd_value = v; u1.upd_last = last;
      end
      cycle();
   endtask

   task automatic idle();
      u0.upd_valid = 1'b0;
      u1.upd_valid = 1'b0;
      cycle();
   endtask

   task automatic pulse_start(input int sel);
      u0.upd_valid = 1'b0;
      u1.upd_valid = 1'b0;
      start0 = (sel == 0);
      start1 = (sel == 1);
      if (sel == 0) exp_nw0 = 0; else exp_nw1 = 0;
      cycle();
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic preload(input int sel, input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en0  = (sel == 0);
      pl_en1  = (sel == 1);
      if (sel == 0) ref0[a[3:0]] = d; else ref1[a[3:0]] = d;
      idle();
      pl_en0 = 1'b0;
      pl_en1 = 1'b0;
   endtask

   // Bounded wait for done; leaves the unit back in IDLE.
   task automatic wait_done(input int sel, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         idle();
         seen = (sel == 0) ? done0 : done1;
      end
      chk(tag, seen, 1'b1);
   endtask

   initial begin
      logic [DATA-1:0] old4;
      u0.upd_valid = 1'b0; u0.upd_addr = '0; u0.upd_value = '0; u0.upd_last = 1'b0;
      u1.upd_valid = 1'b0; u1.upd_addr = '0; u1.upd_value = '0; u1.upd_last = 1'b0;

      // Reset values
      u0.upd_addr  = 16'h1234;
      u0.upd_valid = 1'b1;
      cycle();
      cycle();
      chk("rst_ready", u0.upd_ready, 1'b0);
      chk("rst_a_addr", a_addr0, 16'h1234);
      chk("rst_b_wr", wr0, 1'b0);
      chk("rst_b_addr", b_addr0, '0);
      chk("rst_b_din", din0, '0);
      chk("rst_done", done0, 1'b0);
      chk("rst_changed", changed0, 1'b0);
      chk("rst_nw", nw0, '0);
      u0.upd_valid = 1'b0;
      rst_n = 1'b1;
      idle();
      chk("idle_ready", u0.upd_ready, 1'b0);

      // Basic min with exact done timing
      preload(0, 5, 100);
      preload(0, 7, 10);
      pulse_start(0);
      chk("run_ready", u0.upd_ready, 1'b1);
      send(0, 5, 40, 1'b1);
      chk("t1_done_e0", done0, 1'b0);
      idle();
      chk("t1_done_e1", done0, 1'b0);
      chk("t1_ready_drain", u0.upd_ready, 1'b0);
      idle();
      chk("t1_done_e2", done0, 1'b1);
      chk("t1_changed", changed0, 1'b1);
      chk("t1_nw", nw0, 32'd1);
      idle();
      chk("t1_done_e3", done0, 1'b0);
      chk("t1_ram5", ram0[5], 32'd40);

      // No improvement: no write, done still pulses, counters cleared
      pulse_start(0);
      chk("t2_changed_clr", changed0, 1'b0);
      chk("t2_nw_clr", nw0, '0);
      send(0, 7, 20, 1'b1);
      idle();
      idle();
      chk("t2_done", done0, 1'b1);
      chk("t2_changed", changed0, 1'b0);
      chk("t2_nw", nw0, '0);
      idle();
      chk("t2_ram7", ram0[7], 32'd10);

      // Back-to-back same address, add
      for (int i = 0; i < 16; i++) preload(1, ADDR'(i), '0);
      preload(1, 3, 1);
      pulse_start(1);
      send(1, 3, 2, 1'b0);
      send(1, 3, 4, 1'b0);
      send(1, 3, 8, 1'b1);
      wait_done(1, "t3_done");
      chk("t3_nw", nw1, 32'd3);
      chk("t3_changed", changed1, 1'b1);
      idle();
      chk("t3_ram3", ram1[3], 32'd15);

      // Alternating addresses, add
      pulse_start(1);
      send(1, 1, 1, 1'b0);
      send(1, 2, 1, 1'b0);
      send(1, 1, 1, 1'b0);
      send(1, 2, 1, 1'b1);
      wait_done(1, "t4_done");
      chk("t4_nw", nw1, 32'd4);
      idle();
      chk("t4_ram1", ram1[1], 32'd2);
      chk("t4_ram2", ram1[2], 32'd2);

      // Random min stream
      for (int i = 0; i < 16; i++) preload(0, ADDR'(i), 32'd1000);
      pulse_start(0);
      for (int i = 0; i < 200; i++) begin
         chk("t5_ready", u0.upd_ready, 1'b1);
         send(0, ADDR'($urandom_range(0, 15)), DATA'($urandom_range(0, 1100)), i == 199);
      end
      wait_done(0, "t5_done");
      chk("t5_nw", nw0, 32'(exp_nw0));
      idle();
      for (int i = 0; i < 16; i++) chk($sformatf("t5_ram%0d", i), ram0[i], ref0[i]);

      // Random add stream, 1000 updates
      pulse_start(1);
      for (int i = 0; i < 1000; i++) begin
         chk("t6_ready", u1.upd_ready, 1'b1);
         send(1, ADDR'($urandom_range(0, 15)), DATA'($urandom_range(0, 3)), i == 999);
      end
      wait_done(1, "t6_done");
      chk("t6_nw", nw1, 32'(exp_nw1));
      idle();
      for (int i = 0; i < 16; i++) chk($sformatf("t6_ram%0d", i), ram1[i], ref1[i]);

      // Reset with S2 valid
      pulse_start(1);
      old4 = ref1[4];
      send(1, 4, 5, 1'b0);
      u1.upd_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("t7_b_wr", wr1, 1'b0);
      chk("t7_ready", u1.upd_ready, 1'b0);
      chk("t7_b_addr", b_addr1, '0);
      chk("t7_b_din", din1, '0);
      chk("t7_done", done1, 1'b0);
      chk("t7_changed", changed1, 1'b0);
      chk("t7_nw", nw1, '0);
      chk("t7_a_addr", a_addr1, u1.upd_addr);
      ref1[4] = old4;
      idle();
      rst_n = 1'b1;
      idle();
      chk("t7_ram4_dropped", ram1[4], old4);
      pulse_start(1);
      send(1, 4, 5, 1'b1);
      wait_done(1, "t7_done_after");
      chk("t7_nw_after", nw1, 32'd1);
      idle();
      chk("t7_ram4", ram1[4], old4 + 32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gather_apply_unit.md
# gather_apply_unit

Read-modify-write client for one vertex-property dual-port block RAM in the gather phase. Accepts a stream of (vertex address, update value) pairs and reads the current property through RAM port A. It combines the property with the update (min or add), then writes the result through RAM port B. Same-address back-to-back updates are forwarded internally, so one update per cycle is applied without stalls. Sits between the gather update FIFO and the vertex RAM of one processing element.

## Interface
Parameters:
- DATA, 32, property/update width in bits
- ADDR, 16, vertex address width; RAM depth 2**ADDR
- OP, 0, combine function: 0 = unsigned min (SSSP/BFS), 1 = add modulo 2**DATA (PageRank-style)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a gather run
- upd_valid  in  1  update present
- upd_ready  out  1  unit accepts update this cycle
- upd_addr  in  ADDR  destination vertex
- upd_value  in  DATA  update operand
- upd_last  in  1  marks final update of the run
- mem_a_addr  out  ADDR  RAM port A read address; port A write enable is tied low at the top level
- mem_a_dout  in  DATA  RAM port A registered read data, 1-cycle latency, read-first
- mem_b_wr  out  1  RAM port B write enable
- mem_b_addr  out  ADDR  RAM port B address
- mem_b_din  out  DATA  RAM port B write data
- done  out  1  one-cycle pulse when the run has fully committed
- changed  out  1  sticky: at least one property changed in this run
- num_writes  out  32  count of RAM writes in this run, wrapping

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN on start. Entering RUN clears changed and num_writes.
- RUN to DRAIN on the edge that accepts an update with upd_last=1.
- DRAIN to DONE once S2 is empty.
- DONE to IDLE after one cycle. done=1 only in DONE.
- start outside IDLE is ignored.
- upd_ready = (state==RUN). Acceptance = upd_valid & upd_ready.
- mem_a_addr is combinational: upd_addr, so the RAM samples the read on the acceptance edge.
- Stage S2 holds valid, addr and value of the update accepted on the previous edge.
- Forward register F holds valid, addr and data of the write committed on the previous edge.
- old = (F.valid && F.addr==S2.addr) ? F.data : mem_a_dout.
- OP=0: new = min(old, value); write iff value < old.
- OP=1: new = old + value, truncated to DATA bits; write iff value != 0.
- mem_b_wr = S2.valid & write_cond. mem_b_addr = S2.addr. mem_b_din = new. All three are combinational from S2.
- On each write: F is loaded with the written addr and data, changed is set, and num_writes increments. With no write, F.valid clears.
- Forward condition: the RAM is read-first, so a read on the same edge as a port B write to that address returns stale data. F covers exactly that one-edge gap. Reads two or more edges later see the committed data.
- Reset mid-run: S2 and F are cleared immediately, so mem_b_wr drops asynchronously. An in-flight update is dropped and the FSM returns to IDLE.

## Timing
- Reset values: upd_ready=0, mem_a_addr=upd_addr (pass-through), mem_b_wr=0, mem_b_addr=0, mem_b_din=0, done=0, changed=0, num_writes=0, state IDLE.
- Throughput: 1 update per cycle in RUN, with no bubbles for any address sequence.
- Latency: an update accepted at edge E commits to the RAM at edge E+1.
- done asserts the cycle after the last write commits. From last acceptance at edge E, done is high during the cycle after edge E+2.
- A run with upd_last on the first update behaves identically; no empty runs exist.
- Updates presented in IDLE, DRAIN or DONE are not accepted.

## Structure
- Shared package gather_pkg holds: OP_MIN and OP_ADD constants, the state enum, and the combine function combine(old, value, op) returning new and write_cond.
- The RAM itself is instantiated outside this unit.
- No sub-modules; the S2 and F registers plus the FSM are inline.

## Test plan
- Basic, OP=0: RAM[5]=100. Update (5,40) with last → write RAM[5]=40, done 2 cycles later, changed=1, num_writes=1.
- No-improve, OP=0: RAM[7]=10. Update (7,20) → no write, changed=0, num_writes=0, done still pulses.
- Back-to-back same address, OP=1: RAM[3]=1. Updates (3,2),(3,4),(3,8) on consecutive cycles → writes 3, 7, 15 on consecutive edges, final RAM[3]=15. Exercises forwarding.
- Alternating addresses, OP=1: (1,1),(2,1),(1,1),(2,1) from zero → RAM[1]=2, RAM[2]=2. Exercises the two-edge no-forward path.
- Throughput: 1000 random updates with upd_valid held high → upd_ready stays high, final RAM matches a reference model, num_writes matches.
- Reset mid-run: assert rst_n=0 with S2 valid → mem_b_wr low with no clock edge needed, outputs at reset values. After reset, start works normally.
